matrix_push_ctrl: RTL

Write-side controller for the matrix-vector datapath. It takes a row-major stream of matrix elements over a valid/ready handshake and routes each element with a one-hot push into the per-row FIFO bank, one FIFO per processing element. It counts columns and rows against the run-time matrix length and signals completion. Its FIFOs are the ones the pop controller later drains.

---
 rtl/matrix_push_ctrl_if.sv | 29 ++
 rtl/matrix_push_ctrl.sv | 133 +++++++++++++
 2 files changed

// File: rtl/matrix_push_ctrl_if.sv
// Write-side bus of the matrix push controller: stream handshake in, FIFO bank strobes out.
// master = stream source / FIFO bank side, slave = matrix_push_ctrl.
interface matrix_push_ctrl_if #(
    parameter int unsigned WORD_LENGTH = 8,
    parameter int unsigned N_FIFOS     = 8
);
    logic                   start;
    logic [WORD_LENGTH-1:0] Matrix_length;
    logic [WORD_LENGTH-1:0] data_in;
    logic                   data_valid;
    logic                   data_ready;
    logic [N_FIFOS-1:0]     full;
    logic [N_FIFOS-1:0]     push;
    logic [WORD_LENGTH-1:0] FIFOvalue;
    logic [WORD_LENGTH-1:0] row_index;
    logic [WORD_LENGTH-1:0] col_index;
    logic                   done;
    logic                   error;

    modport master (
        output start, Matrix_length, data_in, data_valid, full,
        input  data_ready, push, FIFOvalue, row_index, col_index, done, error
    );

    modport slave (
        input  start, Matrix_length, data_in, data_valid, full,
        output data_ready, push, FIFOvalue, row_index, col_index, done, error
    );
endinterface

// File: rtl/matrix_push_ctrl.sv
// Write-side controller: routes a row-major L x L element stream into per-row FIFOs with a
// one-hot push, counting columns/rows against the latched length and pulsing done at the end.
// Optional macro PUSH_ERROR_EN adds a sticky error flag (illegal length / stray data).
module matrix_push_ctrl #(
    parameter int unsigned WORD_LENGTH = 8,
    parameter int unsigned N_FIFOS     = 8
) (
    input logic              clk,
    input logic              reset,
    matrix_push_ctrl_if.slave bus
);
    localparam int unsigned            IdxW   = (N_FIFOS > 1) ? $clog2(N_FIFOS) : 1;
    localparam logic [WORD_LENGTH-1:0] MaxLen = WORD_LENGTH'(N_FIFOS);
    localparam logic [WORD_LENGTH-1:0] One    = WORD_LENGTH'(1);

    typedef enum logic [1:0] {StIdle, StLoad, StDone} state_e;

    state_e                 state_q, state_d;
    logic                   start_q;
    logic [WORD_LENGTH-1:0] len_q, len_d;
    logic [WORD_LENGTH-1:0] row_q, row_d;
    logic [WORD_LENGTH-1:0] col_q, col_d;

    logic            start_edge;
    logic            len_legal;
    logic [IdxW-1:0] row_sel;
    logic            row_full;
    logic            accept;
    logic            last_col;
    logic            last_row;

    assign start_edge = bus.start & ~start_q;
    assign len_legal  = (bus.Matrix_length != '0) && (bus.Matrix_length <= MaxLen);
    // row never exceeds L-1 <= N_FIFOS-1, so the low bits address the FIFO directly
    assign row_sel    = row_q[IdxW-1:0];
    assign row_full   = bus.full[row_sel];
    assign accept     = (state_q == StLoad) & bus.data_valid & ~row_full;
    assign last_col   = (col_q == len_q - One);
    assign last_row   = (row_q == len_q - One);

    // State register, counters, latched length and start history
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= StIdle;
            start_q <= 1'b0;
            len_q   <= '0;
            row_q   <= '0;
            col_q   <= '0;
        end else begin
            state_q <= state_d;
            start_q <= bus.start;
            len_q   <= len_d;
            row_q   <= row_d;
            col_q   <= col_d;
        end
    end

    // Next-state and counter advance
    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        row_d   = row_q;
        col_d   = col_q;
        unique case (state_q)
            StIdle: begin
                if (start_edge && len_legal) begin
                    state_d = StLoad;
                    len_d   = bus.Matrix_length;
                    row_d   = '0;
                    col_d   = '0;
                end
            end
            StLoad: begin
                if (accept) begin
                    if (!last_col) begin
                        col_d = col_q + One;
                    end else begin
                        col_d = '0;
                        if (!last_row) begin
                            row_d = row_q + One;
                        end else begin
                            state_d = StDone;
                        end
                    end
                end
            end
            StDone: begin
                state_d = StIdle;
                row_d   = '0;
                col_d   = '0;
            end
            default: state_d = StIdle;
        endcase
    end

    // Outputs: handshake and push are combinational so a push lands in the accept cycle
    always_comb begin
        bus.data_ready = (state_q == StLoad) & ~row_full;
        bus.push       = accept ? (N_FIFOS'(1) << row_sel) : '0;
        bus.FIFOvalue  = bus.data_in;
        bus.row_index  = row_q;
        bus.col_index  = col_q;
        bus.done       = (state_q == StDone);
    end

`ifdef PUSH_ERROR_EN
    logic error_q, error_d;

    // Sticky error: a legal start clears it, an illegal start or stray data sets it
    always_comb begin
        error_d = error_q;
        if (state_q == StIdle && start_edge && len_legal) begin
            error_d = 1'b0;
        end else if ((state_q == StIdle && start_edge && !len_legal) ||
                     (state_q != StLoad && bus.data_valid)) begin
            error_d = 1'b1;
        end
    end

    // Error flag register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            error_q <= 1'b0;
        end else begin
            error_q <= error_d;
        end
    end

    assign bus.error = error_q;
`else
    assign bus.error = 1'b0;
`endif
endmodule
